// File: rtl/mult_requester_pkg.sv
// rtl/mult_requester_pkg.sv - shared types and constants for the multiplier requester
package mult_requester_pkg;

    localparam int MULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } req_state_t;

    // State encoding of the sequential multiplier core this block drives.
    typedef enum logic [2:0] {
        IDLE,
        COMPUTE_BIT_0,
        COMPUTE_BIT_1,
        COMPUTE_BIT_2,
        COMPUTE_BIT_3,
        END_S
    } estado_t;

endpackage

// File: rtl/mult_requester_if.sv
// rtl/mult_requester_if.sv - upstream request, core en/END and downstream response signals
interface mult_requester_if #(
    parameter int WIDTH = mult_requester_pkg::MULT_WIDTH,
    parameter int CNT_W = 8
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [WIDTH-1:0]     req_a_i;
    logic [WIDTH-1:0]     req_b_i;
    logic                 mult_en_o;
    logic [WIDTH-1:0]     mult_a_o;
    logic [WIDTH-1:0]     mult_b_o;
    logic                 mult_done_i;
    logic [2*WIDTH-1:0]   mult_p_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [2*WIDTH-1:0]   rsp_p_o;
    logic                 rsp_err_o;
    logic [CNT_W-1:0]     ops_cnt_o;

    modport master (
        input  req_valid_i, req_a_i, req_b_i, mult_done_i, mult_p_i, rsp_ready_i,
        output req_ready_o, mult_en_o, mult_a_o, mult_b_o,
               rsp_valid_o, rsp_p_o, rsp_err_o, ops_cnt_o
    );

    modport slave (
        output req_valid_i, req_a_i, req_b_i, mult_done_i, mult_p_i, rsp_ready_i,
        input  req_ready_o, mult_en_o, mult_a_o, mult_b_o,
               rsp_valid_o, rsp_p_o, rsp_err_o, ops_cnt_o
    );
endinterface

// File: rtl/mult_req_watchdog.sv
// rtl/mult_req_watchdog.sv - S_RUN cycle counter, built only with MULT_REQ_TIMEOUT_EN
module mult_req_watchdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_cnt_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_cnt_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Fires during the cycle whose edge brings the count to TIMEOUT_CYC.
    assign o_expired = i_cnt_en && (r_cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mult_requester.sv
// rtl/mult_requester.sv - en/END initiator for the sequential multiplier; optional MULT_REQ_TIMEOUT_EN
module mult_requester
    import mult_requester_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 8
`ifdef MULT_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 15
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mult_requester_if.master bus
);
    req_state_t           r_state;
    logic                 r_en;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_valid;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_err;
    logic [CNT_W-1:0]     r_ops;
    logic                 w_req_ready;
    logic                 w_expired;

    // Never start while the core still sits in END, even if it missed our reset.
    assign w_req_ready = (r_state == S_IDLE) && !bus.mult_done_i;

`ifdef MULT_REQ_TIMEOUT_EN
    mult_req_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_clear   (r_state != S_RUN),
        .i_cnt_en  (r_state == S_RUN),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_p     <= '0;
            r_err   <= 1'b0;
            r_ops   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i && w_req_ready) begin
                        r_a     <= bus.req_a_i;
                        r_b     <= bus.req_b_i;
                        r_en    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A completing core wins over a simultaneous timeout.
                    if (bus.mult_done_i) begin
                        r_p     <= bus.mult_p_i;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                        r_en    <= 1'b0;
                        r_state <= S_RESP;
                    end else if (w_expired) begin
                        r_p     <= '0;
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        r_en    <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_valid <= 1'b0;
                        r_ops   <= r_ops + CNT_W'(1);
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.mult_en_o   = r_en;
    assign bus.mult_a_o    = r_a;
    assign bus.mult_b_o    = r_b;
    assign bus.rsp_valid_o = r_valid;
    assign bus.rsp_p_o     = r_p;
    assign bus.rsp_err_o   = r_err;
    assign bus.ops_cnt_o   = r_ops;
endmodule
